btn_conditioner: RTL

//   Conditions the raw push-button inputs of both BitDogLab boards: 2-FF synchronizer,
//   per-channel debounce counter, polarity normalization and one-cycle edge pulses.

---
 rtl/btn_conditioner.sv | 109 ++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel push-button conditioning.
//   Raw pins -> 2-flop synchronizer -> polarity normalization -> debounce
//   counter -> registered level plus one-cycle rise/fall pulses.
//   A level change is accepted only after DB_TICKS consecutive cycles in which
//   the synchronized pin disagrees with the accepted level; any agreeing cycle
//   restarts the window.
// Optional feature macro: BTN_TOGGLE_EN adds the btn_toggle output, a
//   per-channel bit that flips one cycle after each accepted press.
module btn_conditioner #(
  parameter int F_CLK_HZ    = 25_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int N_BTN       = 6,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall
`ifdef BTN_TOGGLE_EN
  ,
  output logic [N_BTN-1:0] btn_toggle
`endif
);

  // A zero-length window would never accept anything, so clamp to one tick.
  localparam int DB_RAW   = (F_CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int DB_TICKS = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int CNT_W    = $clog2(DB_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_TICKS - 1);

  // Pins idle at their released level out of reset so no edge is seen at release.
  localparam logic [N_BTN-1:0] IDLE_RAW = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

  logic [N_BTN-1:0] sync_p0;
  logic [N_BTN-1:0] sync_p1;
  logic [N_BTN-1:0] sync_n;
  logic [N_BTN-1:0] accept;
  logic [CNT_W-1:0] cnt     [N_BTN];
  logic [CNT_W-1:0] cnt_nxt [N_BTN];

  // Stage p0/p1: two-flop synchronizer on the asynchronous pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= IDLE_RAW;
      sync_p1 <= IDLE_RAW;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Normalize so that 1 always means pressed from here on.
  assign sync_n = (ACTIVE_LOW != 0) ? ~sync_p1 : sync_p1;

  // Debounce decision: count disagreeing cycles, accept on the last one.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_nxt[i] = '0;
      if (sync_n[i] != btn_level[i]) begin
        if (cnt[i] == CNT_LAST) begin
          accept[i] = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounce window counters, one per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Stage p2: accepted level and its edge pulses, all registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level <= '0;
      btn_rise  <= '0;
      btn_fall  <= '0;
    end else begin
      btn_level <= btn_level ^ accept;
      btn_rise  <= accept & sync_n;
      btn_fall  <= accept & ~sync_n;
    end
  end

`ifdef BTN_TOGGLE_EN
  // Toggle state flips on each press pulse; releases are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_toggle <= '0;
    end else begin
      btn_toggle <= btn_toggle ^ btn_rise;
    end
  end
`endif

endmodule
